// File: rtl/error_reconstruct.sv
// Block-wise error reconstruction: unmaps decoded errors, adds them to the prediction,
// clamps to the sample range and tracks the adaptive Golomb parameter per block.
module error_reconstruct #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int ACC_LOG        = 5,
    parameter int DELTA          = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         d_flag_valid,
    output logic                         d_flag_ready,
    input  logic                         d_flag_data,
    input  logic                         prediction_valid,
    output logic                         prediction_ready,
    input  logic signed [DATA_WIDTH+2:0] prediction_data,
    input  logic                         merr_valid,
    output logic                         merr_ready,
    input  logic        [DATA_WIDTH+2:0] merr_data,
    output logic                         kj_valid,
    input  logic                         kj_ready,
    output logic        [ACC_LOG-1:0]    kj_data,
    output logic                         xhat_valid,
    input  logic                         xhat_ready,
    output logic        [DATA_WIDTH-1:0] xhat_data
);

    localparam int IW   = DATA_WIDTH + 3;
    localparam int AW   = IW + BLOCK_SIZE_LOG;
    localparam int CW   = BLOCK_SIZE_LOG + 1;
    localparam int KMAX = 2**ACC_LOG - 1;
    localparam int SW   = AW + CW + KMAX;
    localparam int RW   = DATA_WIDTH + 7 + $clog2(2*DELTA + 2);

    localparam logic [BLOCK_SIZE_LOG-1:0] LAST  = '1;
    localparam logic signed [RW-1:0]      SCALE = RW'(2*DELTA + 1);
    localparam logic signed [RW-1:0]      MAXV  = {{(RW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    typedef enum logic [2:0] {FLAG, KJ, DECODE, SKIP, OUT} state_t;

    state_t                    state;
    logic                      skip_blk;
    logic [BLOCK_SIZE_LOG-1:0] sample_cnt;
    logic [AW-1:0]             acc;
    logic [CW-1:0]             cnt;

    logic signed [RW-1:0] merr_ext;
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] err;
    logic signed [RW-1:0] pred_ext;
    logic signed [RW-1:0] recon;
    logic                 joined;

    // Smallest k with (cnt << k) >= acc; stays at KMAX when no k qualifies.
    function automatic logic [ACC_LOG-1:0] calc_kj(input logic [AW-1:0] a, input logic [CW-1:0] c);
        logic [SW-1:0]      ce;
        logic [SW-1:0]      ae;
        logic [ACC_LOG-1:0] k;
        ce = SW'(c);
        ae = SW'(a);
        k  = ACC_LOG'(KMAX);
        for (int i = KMAX; i >= 0; i--) begin
            if ((ce << i) >= ae) k = ACC_LOG'(i);
        end
        return k;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [RW-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v < 0)         r = '0;
        else if (v > MAXV) r = '1;
        else               r = v[DATA_WIDTH-1:0];
        return r;
    endfunction

    // Odd mapped errors are negative: e = -(merr+1)/2, even ones e = merr/2.
    always_comb begin
        merr_ext = RW'(merr_data);
        half     = (merr_ext + RW'(merr_data[0])) >>> 1;
        err      = merr_data[0] ? -half : half;
        pred_ext = RW'(prediction_data);
        recon    = pred_ext + err * SCALE;
    end

    assign joined           = merr_valid && prediction_valid;
    assign d_flag_ready     = (state == FLAG);
    assign merr_ready       = (state == DECODE) && joined;
    assign prediction_ready = (state == SKIP) || ((state == DECODE) && joined);
    assign kj_valid         = (state == KJ);
    assign xhat_valid       = (state == OUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FLAG;
            skip_blk   <= 1'b0;
            sample_cnt <= '0;
            acc        <= '0;
            cnt        <= CW'(1);
            kj_data    <= '0;
            xhat_data  <= '0;
        end else begin
            unique case (state)
                FLAG: if (d_flag_valid) begin
                    acc        <= '0;
                    cnt        <= CW'(1);
                    sample_cnt <= '0;
                    skip_blk   <= d_flag_data;
                    if (d_flag_data) begin
                        state <= SKIP;
                    end else begin
                        kj_data <= '0;
                        state   <= KJ;
                    end
                end
                KJ: if (kj_ready) state <= DECODE;
                DECODE: if (joined) begin
                    acc       <= acc + AW'(merr_data);
                    cnt       <= cnt + CW'(1);
                    xhat_data <= clamp(recon);
                    state     <= OUT;
                end
                SKIP: if (prediction_valid) begin
                    xhat_data <= clamp(pred_ext);
                    state     <= OUT;
                end
                OUT: if (xhat_ready) begin
                    sample_cnt <= sample_cnt + BLOCK_SIZE_LOG'(1);
                    if (sample_cnt == LAST) begin
                        state <= FLAG;
                    end else if (skip_blk) begin
                        state <= SKIP;
                    end else begin
                        kj_data <= calc_kj(acc, cnt);
                        state   <= KJ;
                    end
                end
                default: state <= FLAG;
            endcase
        end
    end

endmodule
